// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - forwarding and load-use hazard scoreboard for the EX operand muxes
//
// Tracks every accepted register-writing instruction through NSTG downstream
// stages (0 = MEM, 1 = WB, ...) and, per source operand, selects the youngest
// in-flight result once it is available, or raises a stall when it is not.
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   flush_i             drop every tracked instruction and the one in the issue slot
//   issue_valid_i       instruction present in the issue slot
//   issue_we_i          it writes a register
//   issue_rd_i          its destination register
//   issue_rdy_i         first stage index whose stg_data holds its result
//   src_addr_i          source register addresses, operand i at [i*AW +: AW]
//   src_use_i           operand i is actually read
//   rf_data_i           register-file read data per operand
//   stg_data_i          result data held in stage k, at [k*DW +: DW]
//   fw_data_o           selected operand data
//   fw_hit_o            operand i taken from the pipeline
//   fw_stg_o            stage index forwarded from (0 when no hit)
//   stall_o             issue slot must hold
//   stall_cnt_o         saturating count of stall cycles

module fwd_scoreboard #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSTG = 3,
  parameter int NSRC = 2,
  parameter int SW   = $clog2(NSTG) + 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  input  logic               issue_we_i,
  input  logic [AW-1:0]      issue_rd_i,
  input  logic [SW-1:0]      issue_rdy_i,
  input  logic [NSRC*AW-1:0] src_addr_i,
  input  logic [NSRC-1:0]    src_use_i,
  input  logic [NSRC*DW-1:0] rf_data_i,
  input  logic [NSTG*DW-1:0] stg_data_i,
  output logic [NSRC*DW-1:0] fw_data_o,
  output logic [NSRC-1:0]    fw_hit_o,
  output logic [NSRC*SW-1:0] fw_stg_o,
  output logic               stall_o,
  output logic [15:0]        stall_cnt_o
);

  // Tracker: entry k holds the instruction accepted k+1 cycles ago.
  logic [NSTG-1:0] valid_q, valid_d;
  logic [NSTG-1:0] we_q;
  logic [AW-1:0]   rd_q  [NSTG];
  logic [SW-1:0]   rdy_q [NSTG];
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [NSRC-1:0] pending;
  logic [AW-1:0]   src;
  logic            found;
  logic [SW-1:0]   hit_stg;
  logic [SW-1:0]   hit_rdy;
  logic [DW-1:0]   hit_data;

  // Operand lookup and hazard detection.
  always_comb begin
    fw_data_o = rf_data_i;
    fw_hit_o  = '0;
    fw_stg_o  = '0;
    pending   = '0;
    src       = '0;
    found     = 1'b0;
    hit_stg   = '0;
    hit_rdy   = '0;
    hit_data  = '0;
    for (int i = 0; i < NSRC; i++) begin
      src      = src_addr_i[i*AW +: AW];
      found    = 1'b0;
      hit_stg  = '0;
      hit_rdy  = '0;
      hit_data = '0;
      // r0 is hardwired; a nonzero src also keeps rd==0 entries from matching.
      if (src_use_i[i] && (src != '0)) begin
        // Scan oldest to youngest so the youngest match is the one left standing.
        for (int k = NSTG - 1; k >= 0; k--) begin
          if (valid_q[k] && we_q[k] && (rd_q[k] == src)) begin
            found    = 1'b1;
            hit_stg  = SW'(k);
            hit_rdy  = rdy_q[k];
            hit_data = stg_data_i[k*DW +: DW];
          end
        end
      end
      if (found) begin
        if (hit_stg >= hit_rdy) begin
          fw_hit_o[i]             = 1'b1;
          fw_stg_o[i*SW +: SW]    = hit_stg;
          fw_data_o[i*DW +: DW]   = hit_data;
        end else begin
          // Youngest producer has not reached its result stage yet; an older
          // ready match must not be used instead.
          pending[i] = 1'b1;
        end
      end
    end
    stall_o = issue_valid_i && (|pending);
  end

  // Next-state for tracker valid bits and the stall counter.
  always_comb begin
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      valid_d[0] = issue_valid_i && !stall_o;
      for (int k = 1; k < NSTG; k++) begin
        valid_d[k] = valid_q[k-1];
      end
    end
    if (stall_o && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload fields are only meaningful under valid, so they shift unreset.
  always_ff @(posedge clk_i) begin
    we_q[0]  <= issue_we_i;
    rd_q[0]  <= issue_rd_i;
    rdy_q[0] <= issue_rdy_i;
    for (int k = 1; k < NSTG; k++) begin
      we_q[k]  <= we_q[k-1];
      rd_q[k]  <= rd_q[k-1];
      rdy_q[k] <= rdy_q[k-1];
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
